// File: rtl/traffic_light_ctrl_if.sv
// Traffic-light interface: carries the 2-bit light code from the sequencer
// (controller/master side) to whatever displays or monitors it (slave side).
interface traffic_light_ctrl_if;
  logic [1:0] out;

  modport controller (output out);
  modport master     (output out);
  modport slave      (input  out);
endinterface

// File: rtl/traffic_light_ctrl.sv
// Free-running green -> yellow -> red sequencer with per-phase dwell counts.
// Define TRAFFIC_LIGHT_CUR_OUT_EN to drive the current phase instead of the look-ahead phase.
module traffic_light_ctrl #(
  parameter int GREEN_CYCLES  = 1,
  parameter int YELLOW_CYCLES = 1,
  parameter int RED_CYCLES    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_light_ctrl_if.controller tl
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_RED    = 2'b10,
    PH_BAD    = 2'b11
  } phase_e;

  localparam logic [7:0] GREEN_DWELL  = 8'(GREEN_CYCLES);
  localparam logic [7:0] YELLOW_DWELL = 8'(YELLOW_CYCLES);
  localparam logic [7:0] RED_DWELL    = 8'(RED_CYCLES);

  if (GREEN_CYCLES < 1 || GREEN_CYCLES > 255) begin : g_bad_green
    $error("traffic_light_ctrl: GREEN_CYCLES must be in 1..255");
  end
  if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 255) begin : g_bad_yellow
    $error("traffic_light_ctrl: YELLOW_CYCLES must be in 1..255");
  end
  if (RED_CYCLES < 1 || RED_CYCLES > 255) begin : g_bad_red
    $error("traffic_light_ctrl: RED_CYCLES must be in 1..255");
  end

  // Phase register is plain 2-bit so the unused code 2'b11 stays representable.
  logic [1:0] phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dwell;
  logic [1:0] succ;
  logic       illegal;
  logic       last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_RED;
      cnt_q   <= 8'd0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    dwell   = 8'd1;
    succ    = PH_RED;
    illegal = 1'b0;
    case (phase_q)
      PH_GREEN: begin
        dwell = GREEN_DWELL;
        succ  = PH_YELLOW;
      end
      PH_YELLOW: begin
        dwell = YELLOW_DWELL;
        succ  = PH_RED;
      end
      PH_RED: begin
        dwell = RED_DWELL;
        succ  = PH_GREEN;
      end
      default: begin
        dwell   = 8'd1;
        succ    = PH_RED;
        illegal = 1'b1;
      end
    endcase

    last = (cnt_q == dwell - 8'd1);

    phase_d = phase_q;
    cnt_d   = cnt_q + 8'd1;
    if (illegal) begin
      phase_d = PH_RED;
      cnt_d   = 8'd0;
    end else if (last) begin
      phase_d = succ;
      cnt_d   = 8'd0;
    end

`ifdef TRAFFIC_LIGHT_CUR_OUT_EN
    tl.out = illegal ? PH_RED : phase_q;
`else
    // Look-ahead: show the phase that the next edge will produce.
    if (illegal) begin
      tl.out = PH_RED;
    end else if (last) begin
      tl.out = succ;
    end else begin
      tl.out = phase_q;
    end
`endif
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: default dwells and a 3/1/2 dwell instance side by side.
module tb_traffic_light_ctrl;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [1:0] exp_def [9];
  logic [1:0] exp_p   [9];

  traffic_light_ctrl_if tl_def ();
  traffic_light_ctrl_if tl_p ();

  traffic_light_ctrl u_def (
    .clk   (clk),
    .reset (reset),
    .tl    (tl_def.controller)
  );

  traffic_light_ctrl #(
    .GREEN_CYCLES  (3),
    .YELLOW_CYCLES (1),
    .RED_CYCLES    (2)
  ) u_p (
    .clk   (clk),
    .reset (reset),
    .tl    (tl_p.controller)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if (tl_def.out !== exp_def[0]) begin
      bad++;
      $display("FAIL reset_def_t1: got %b want %b", tl_def.out, exp_def[0]);
    end
    total++;
    if (tl_p.out !== exp_p[0]) begin
      bad++;
      $display("FAIL reset_p_t1: got %b want %b", tl_p.out, exp_p[0]);
    end
    @(negedge clk);
    total++;
    if (tl_def.out !== exp_def[0]) begin
      bad++;
      $display("FAIL reset_def_held: got %b want %b", tl_def.out, exp_def[0]);
    end
    total++;
    if (tl_p.out !== exp_p[0]) begin
      bad++;
      $display("FAIL reset_p_held: got %b want %b", tl_p.out, exp_p[0]);
    end
    @(negedge clk);
    total++;
    if (tl_def.out !== exp_def[0]) begin
      bad++;
      $display("FAIL reset_def_held2: got %b want %b", tl_def.out, exp_def[0]);
    end
    reset = 1'b0;
    $display("reset: def=%b p=%b", tl_def.out, tl_p.out);
  endtask

  task automatic test_sequence();
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (tl_def.out !== exp_def[i]) begin
        bad++;
        $display("FAIL seq_def[%0d]: got %b want %b", i, tl_def.out, exp_def[i]);
      end
      total++;
      if (tl_p.out !== exp_p[i]) begin
        bad++;
        $display("FAIL seq_p[%0d]: got %b want %b", i, tl_p.out, exp_p[i]);
      end
      $display("edge %0d: def=%b p=%b", i, tl_def.out, tl_p.out);
    end
  endtask

  // Entered 1 ns after the 8th edge: default instance sits in yellow.
  task automatic test_async_reset();
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (tl_def.out !== exp_def[0]) begin
      bad++;
      $display("FAIL async_def: got %b want %b", tl_def.out, exp_def[0]);
    end
    total++;
    if (tl_p.out !== exp_p[0]) begin
      bad++;
      $display("FAIL async_p: got %b want %b", tl_p.out, exp_p[0]);
    end
    @(posedge clk);
    #1;
    total++;
    if (tl_def.out !== exp_def[0]) begin
      bad++;
      $display("FAIL async_def_hold: got %b want %b", tl_def.out, exp_def[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (tl_def.out !== exp_def[i]) begin
        bad++;
        $display("FAIL restart_def[%0d]: got %b want %b", i, tl_def.out, exp_def[i]);
      end
      total++;
      if (tl_p.out !== exp_p[i]) begin
        bad++;
        $display("FAIL restart_p[%0d]: got %b want %b", i, tl_p.out, exp_p[i]);
      end
      $display("restart edge %0d: def=%b p=%b", i, tl_def.out, tl_p.out);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] want_def1, want_p1, want_def2, want_p2;
`ifdef TRAFFIC_LIGHT_CUR_OUT_EN
    want_def1 = 2'b10; want_p1 = 2'b10;
    want_def2 = 2'b00; want_p2 = 2'b10;
`else
    want_def1 = 2'b00; want_p1 = 2'b10;
    want_def2 = 2'b01; want_p2 = 2'b00;
`endif
    @(negedge clk);
    force u_def.phase_q = 2'b11;
    force u_p.phase_q   = 2'b11;
    #1;
    total++;
    if (tl_def.out !== 2'b10) begin
      bad++;
      $display("FAIL illegal_def_out: got %b want %b", tl_def.out, 2'b10);
    end
    total++;
    if (tl_p.out !== 2'b10) begin
      bad++;
      $display("FAIL illegal_p_out: got %b want %b", tl_p.out, 2'b10);
    end
    release u_def.phase_q;
    release u_p.phase_q;
    @(posedge clk);
    #1;
    total++;
    if (tl_def.out !== want_def1) begin
      bad++;
      $display("FAIL recover_def: got %b want %b", tl_def.out, want_def1);
    end
    total++;
    if (tl_p.out !== want_p1) begin
      bad++;
      $display("FAIL recover_p: got %b want %b", tl_p.out, want_p1);
    end
    @(posedge clk);
    #1;
    total++;
    if (tl_def.out !== want_def2) begin
      bad++;
      $display("FAIL recover_def2: got %b want %b", tl_def.out, want_def2);
    end
    total++;
    if (tl_p.out !== want_p2) begin
      bad++;
      $display("FAIL recover_p2: got %b want %b", tl_p.out, want_p2);
    end
    $display("illegal recovery: def=%b p=%b", tl_def.out, tl_p.out);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    // Index 0 = value while in reset, index i = value after the i-th edge.
`ifdef TRAFFIC_LIGHT_CUR_OUT_EN
    exp_def = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
    exp_p   = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
`else
    exp_def = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    exp_p   = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
`endif
    test_reset();
    test_sequence();
    test_async_reset();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
